// File: rtl/pn_pkg.sv
// Shared definitions for the PN generator/checker pair.
// The default polynomial lives here so that both ends of a link use the same one.
package pn_pkg;

    localparam int unsigned PN_W_DEFAULT = 3;
    localparam logic [PN_W_DEFAULT-1:0] PN_TAPS_DEFAULT = 3'b110;

    // data_out field layout
    localparam int unsigned DO_W          = 2;
    localparam int unsigned DO_LOCKED_BIT = 1;
    localparam int unsigned DO_ERR_BIT    = 0;

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } pn_state_e;

    typedef struct packed {
        logic judged_locked;
        logic bit_err;
    } pn_result_t;

endpackage

// File: rtl/pn_lfsr_predict.sv
// Next-bit prediction of a Fibonacci LFSR: XOR of the tapped history bits.
// Ports:
//   sr        in  W  bit history, sr[0] = newest bit
//   predict_c out 1  predicted next bit (combinational)
module pn_lfsr_predict
    import pn_pkg::*;
#(
    parameter int unsigned    W    = PN_W_DEFAULT,
    parameter logic [W-1:0]   TAPS = W'(PN_TAPS_DEFAULT)
) (
    input  logic [W-1:0] sr,
    output logic         predict_c
);

    assign predict_c = ^(sr & TAPS);

endmodule

// File: rtl/pn_sequence_checker.sv
// Receive-side PN checker: self-synchronises a local LFSR to the incoming
// serial stream, then flywheels it and flags every disagreeing bit.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   valid/ready     input beat handshake, pn_seq_in is the received bit
//   axi_tvalid      result valid, data_out_ready is the downstream accept
//   data_out        {judged_in_locked, bit_err}
//   locked          checker is in LOCKED
//   clr_cnt         clears err_cnt and bit_cnt
//   err_cnt/bit_cnt saturating error / judged-bit counters (LOCKED only)
module pn_sequence_checker
    import pn_pkg::*;
#(
    parameter int unsigned                LFSR_WIDTH = PN_W_DEFAULT,
    parameter logic [LFSR_WIDTH-1:0]      TAPS       = LFSR_WIDTH'(PN_TAPS_DEFAULT),
    parameter int unsigned                LOCK_CNT   = 7,
    parameter int unsigned                WIN_LEN    = 16,
    parameter int unsigned                ERR_LIMIT  = 4,
    parameter int unsigned                CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    output logic                 ready,
    input  logic                 pn_seq_in,
    input  logic                 data_out_ready,
    output logic                 axi_tvalid,
    output logic [DO_W-1:0]      data_out,
    output logic                 locked,
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] bit_cnt
);

    localparam int unsigned W  = LFSR_WIDTH;
    localparam int unsigned FW = $clog2(W + 1);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned PW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

    pn_state_e      state, state_nx;
    logic [W-1:0]   sr, sr_nx;
    logic [FW-1:0]  fill_cnt, fill_nx;
    logic [GW-1:0]  good_cnt, good_nx;
    logic [PW-1:0]  win_pos, win_pos_nx;
    logic [EW-1:0]  win_err, win_err_nx, win_err_sum;
    logic [CNT_WIDTH-1:0] err_nx, bit_nx;
    logic           tvalid_nx, locked_nx;
    pn_result_t     result_q, result_nx;
    logic           accept, pred, judged, bit_err;

    // Single-entry output register: a new beat is taken whenever the slot frees up.
    assign ready  = !axi_tvalid || data_out_ready;
    assign accept = valid && ready;

    assign data_out[DO_LOCKED_BIT] = result_q.judged_locked;
    assign data_out[DO_ERR_BIT]    = result_q.bit_err;

    pn_lfsr_predict #(.W(W), .TAPS(TAPS)) u_predict (
        .sr        (sr),
        .predict_c (pred)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ACQ;
            sr         <= '0;
            fill_cnt   <= '0;
            good_cnt   <= '0;
            win_pos    <= '0;
            win_err    <= '0;
            err_cnt    <= '0;
            bit_cnt    <= '0;
            axi_tvalid <= 1'b0;
            result_q   <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nx;
            sr         <= sr_nx;
            fill_cnt   <= fill_nx;
            good_cnt   <= good_nx;
            win_pos    <= win_pos_nx;
            win_err    <= win_err_nx;
            err_cnt    <= err_nx;
            bit_cnt    <= bit_nx;
            axi_tvalid <= tvalid_nx;
            result_q   <= result_nx;
            locked     <= locked_nx;
        end
    end

    // Next-state, sync/lock tracking, counters and result generation
    always_comb begin
        state_nx    = state;
        sr_nx       = sr;
        fill_nx     = fill_cnt;
        good_nx     = good_cnt;
        win_pos_nx  = win_pos;
        win_err_nx  = win_err;
        win_err_sum = win_err;
        err_nx      = err_cnt;
        bit_nx      = bit_cnt;
        tvalid_nx   = axi_tvalid;
        result_nx   = result_q;
        judged      = 1'b0;
        bit_err     = 1'b0;

        if (data_out_ready) begin
            tvalid_nx = 1'b0;
        end

        if (accept) begin
            unique case (state)
                ST_ACQ: begin
                    sr_nx = {sr[W-2:0], pn_seq_in};
                    if (fill_cnt != FW'(W)) begin
                        fill_nx = fill_cnt + FW'(1);
                    end
                    // An all-zero history is not a PN state; keep filling.
                    if ((fill_nx == FW'(W)) && (sr_nx != '0)) begin
                        state_nx = ST_CHECK;
                        good_nx  = '0;
                    end
                end
                ST_CHECK: begin
                    sr_nx = {sr[W-2:0], pn_seq_in};
                    if (pn_seq_in != pred) begin
                        bit_err  = 1'b1;
                        state_nx = ST_ACQ;
                        fill_nx  = FW'(1);
                    end else if (sr_nx == '0) begin
                        state_nx = ST_ACQ;
                        fill_nx  = '0;
                    end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
                        state_nx   = ST_LOCKED;
                        win_pos_nx = '0;
                        win_err_nx = '0;
                    end else begin
                        good_nx = good_cnt + GW'(1);
                    end
                end
                ST_LOCKED: begin
                    judged = 1'b1;
                    // Flywheel on the prediction so line errors never corrupt the local LFSR.
                    sr_nx  = {sr[W-2:0], pred};
                    if (bit_cnt != '1) begin
                        bit_nx = bit_cnt + CNT_WIDTH'(1);
                    end
                    if (pn_seq_in != pred) begin
                        bit_err     = 1'b1;
                        win_err_sum = win_err + EW'(1);
                        if (err_cnt != '1) begin
                            err_nx = err_cnt + CNT_WIDTH'(1);
                        end
                    end
                    if (win_err_sum == EW'(ERR_LIMIT)) begin
                        state_nx   = ST_ACQ;
                        fill_nx    = '0;
                        sr_nx      = '0;
                        win_pos_nx = '0;
                        win_err_nx = '0;
                    end else if (win_pos == PW'(WIN_LEN - 1)) begin
                        win_pos_nx = '0;
                        win_err_nx = '0;
                    end else begin
                        win_pos_nx = win_pos + PW'(1);
                        win_err_nx = win_err_sum;
                    end
                end
                default: begin
                    state_nx = ST_ACQ;
                    fill_nx  = '0;
                    sr_nx    = '0;
                end
            endcase
            tvalid_nx               = 1'b1;
            result_nx.judged_locked = judged;
            result_nx.bit_err       = bit_err;
        end

        // Clear wins over a coincident increment.
        if (clr_cnt) begin
            err_nx = '0;
            bit_nx = '0;
        end

        locked_nx = (state_nx == ST_LOCKED);
    end

endmodule

// File: tb/tb_pn_sequence_checker.sv
// Directed bench for pn_sequence_checker using the period-7 stream 1,0,0,1,0,1,1.
module tb_pn_sequence_checker;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid;
    logic          ready;
    logic          pn_seq_in;
    logic          data_out_ready;
    logic          axi_tvalid;
    logic [1:0]    data_out;
    logic          locked;
    logic          clr_cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] bit_cnt;

    int total = 0;
    int bad   = 0;
    int ph    = 0;
    logic [6:0] pat = 7'b1101001;  // pat[i] = i-th bit of the period
    logic b;

    pn_sequence_checker dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .ready          (ready),
        .pn_seq_in      (pn_seq_in),
        .data_out_ready (data_out_ready),
        .axi_tvalid     (axi_tvalid),
        .data_out       (data_out),
        .locked         (locked),
        .clr_cnt        (clr_cnt),
        .err_cnt        (err_cnt),
        .bit_cnt        (bit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_bit(output logic r);
        r  = pat[ph];
        ph = (ph == 6) ? 0 : ph + 1;
    endtask

    task automatic beat(input logic r);
        @(negedge clk);
        valid          = 1'b1;
        pn_seq_in      = r;
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        valid          = 1'b0;
        data_out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; pn_seq_in = 1'b0;
        data_out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  ready,      1);
        chk("rst_tvalid", axi_tvalid, 0);
        chk("rst_dout",   data_out,   0);
        chk("rst_locked", locked,     0);
        chk("rst_err",    err_cnt,    0);
        chk("rst_bits",   bit_cnt,    0);
        @(negedge clk);
        reset = 1'b0;

        // 1: acquisition - 3 fill bits + 7 checked bits, then judged in LOCKED
        for (int k = 1; k <= 21; k++) begin
            get_bit(b);
            beat(b);
            chk("t1_tvalid", axi_tvalid, 1);
            chk("t1_dout",   data_out,   (k > 10) ? 2 : 0);
            chk("t1_locked", locked,     (k >= 10) ? 1 : 0);
        end
        chk("t1_bits", bit_cnt, 11);
        chk("t1_err",  err_cnt, 0);

        // 2: single inverted bit while locked; flywheel keeps following bits clean
        get_bit(b);
        beat(~b);
        chk("t2_dout_err", data_out, 3);
        chk("t2_err",      err_cnt,  1);
        chk("t2_locked",   locked,   1);
        for (int k = 0; k < 4; k++) begin
            get_bit(b);
            beat(b);
            chk("t2_dout_ok", data_out, 2);
            chk("t2_locked2", locked,   1);
        end
        chk("t2_bits", bit_cnt, 16);

        // 3: window has just wrapped; 4 errors in 7 beats force loss of lock
        for (int i = 0; i < 7; i++) begin
            get_bit(b);
            beat(((i % 2) == 0) ? ~b : b);
            chk("t3_dout",   data_out, ((i % 2) == 0) ? 3 : 2);
            chk("t3_locked", locked,   (i == 6) ? 0 : 1);
        end
        chk("t3_err",  err_cnt, 5);
        chk("t3_bits", bit_cnt, 23);
        for (int k = 1; k <= 10; k++) begin
            get_bit(b);
            beat(b);
            chk("t3_relock_dout",   data_out, 0);
            chk("t3_relock_locked", locked,   (k == 10) ? 1 : 0);
        end
        chk("t3_relock_bits", bit_cnt, 23);

        // 5: backpressure - one beat accepted, then stalled for 9 cycles
        idle();
        chk("t5_idle_tvalid", axi_tvalid, 0);
        chk("t5_idle_ready",  ready,      1);
        @(negedge clk);
        get_bit(b);
        valid = 1'b1; pn_seq_in = ~b; data_out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_first_tvalid", axi_tvalid, 1);
        chk("t5_first_dout",   data_out,   3);
        chk("t5_first_ready",  ready,      0);
        chk("t5_first_err",    err_cnt,    6);
        chk("t5_first_bits",   bit_cnt,    24);
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            chk("t5_hold_ready",  ready,      0);
            chk("t5_hold_tvalid", axi_tvalid, 1);
            chk("t5_hold_dout",   data_out,   3);
            chk("t5_hold_bits",   bit_cnt,    24);
        end
        @(negedge clk);
        get_bit(b);
        pn_seq_in = b; data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("t5_rel_dout",   data_out, 2);
        chk("t5_rel_bits",   bit_cnt,  25);
        chk("t5_rel_locked", locked,   1);

        // 6: clear coincident with an error beat, then reset while locked
        @(negedge clk);
        get_bit(b);
        valid = 1'b1; pn_seq_in = ~b; clr_cnt = 1'b1; data_out_ready = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0; clr_cnt = 1'b0;
        chk("t6_clr_err",    err_cnt,  0);
        chk("t6_clr_bits",   bit_cnt,  0);
        chk("t6_clr_dout",   data_out, 3);
        chk("t6_clr_locked", locked,   1);
        get_bit(b);
        beat(b);
        chk("t6_after_bits", bit_cnt, 1);
        chk("t6_after_err",  err_cnt, 0);
        @(negedge clk);
        get_bit(b);
        reset = 1'b1; valid = 1'b1; pn_seq_in = b;
        @(posedge clk);
        #1;
        chk("t6_rst_locked", locked,     0);
        chk("t6_rst_tvalid", axi_tvalid, 0);
        chk("t6_rst_dout",   data_out,   0);
        chk("t6_rst_err",    err_cnt,    0);
        chk("t6_rst_bits",   bit_cnt,    0);
        @(negedge clk);
        reset = 1'b0; valid = 1'b0;

        // 4: all-zero stream never leaves acquisition
        for (int k = 0; k < 20; k++) begin
            beat(1'b0);
            chk("t4_tvalid", axi_tvalid, 1);
            chk("t4_dout",   data_out,   0);
            chk("t4_locked", locked,     0);
        end
        idle();
        chk("t4_idle_tvalid", axi_tvalid, 0);
        chk("t4_bits",        bit_cnt,    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
